ps2_digit_entry_ctrl: RTL and testbench

Controller that turns a stream of PS/2 set-2 scancode bytes into a committed multi-digit decimal number. It tracks the make/break (0xF0) and extended (0xE0) prefixes, decodes digit keys 0-9 through a scancode-to-digit decoder, and keeps an editable BCD entry buffer with backspace, clear and enter. It sits between the PS/2 byte receiver and any consumer of numeric keypad entry. Committed numbers are handed over on a valid/ready handshake.

---
 rtl/ps2_kbd_pkg.sv | 18 +
 rtl/ps2_digit_decode.sv | 26 ++
 rtl/ps2_digit_entry_ctrl.sv | 123 ++++++++++++
 tb/tb_ps2_digit_entry_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 set-2 scancode constants and the entry controller state encoding.
package ps2_kbd_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_ESC   = 8'h76;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EXT     = 3'd1,
      BRK     = 3'd2,
      EXT_BRK = 3'd3,
      COMMIT  = 3'd4
   } state_e;

endpackage

// File: rtl/ps2_digit_decode.sv
// Combinational map from set-2 make codes of the main-row digit keys to a BCD digit.
module ps2_digit_decode (
   input  logic [7:0] code,
   output logic [3:0] digit,
   output logic       is_digit
);

   always_comb begin
      digit    = 4'd0;
      is_digit = 1'b1;
      case (code)
         8'h45:   digit = 4'd0;
         8'h16:   digit = 4'd1;
         8'h1E:   digit = 4'd2;
         8'h26:   digit = 4'd3;
         8'h25:   digit = 4'd4;
         8'h2E:   digit = 4'd5;
         8'h36:   digit = 4'd6;
         8'h3D:   digit = 4'd7;
         8'h3E:   digit = 4'd8;
         8'h46:   digit = 4'd9;
         default: is_digit = 1'b0;
      endcase
   end

endmodule

// File: rtl/ps2_digit_entry_ctrl.sv
// Turns PS/2 scancode bytes into an editable BCD entry buffer and hands committed
// numbers to a consumer over a valid/ready handshake.
module ps2_digit_entry_ctrl
   import ps2_kbd_pkg::*;
#(
   parameter int unsigned NDIG = 4
) (
   input  logic                      clk,
   input  logic                      areset_n,
   input  logic                      sc_valid,
   input  logic [7:0]                sc_data,
   output logic                      sc_ready,
   output logic                      num_valid,
   input  logic                      num_ready,
   output logic [4*NDIG-1:0]         num_bcd,
   output logic [$clog2(NDIG+1)-1:0] num_len,
   output logic                      overflow,
   output logic                      ignored
);

   localparam int unsigned BW = 4 * NDIG;
   localparam int unsigned LW = $clog2(NDIG + 1);

   state_e          state_q, state_d;
   logic [BW-1:0]   buf_q, buf_d;
   logic [LW-1:0]   len_q, len_d;
   logic            ovf_q, ovf_d;
   logic            ign_q, ign_d;
   logic [3:0]      dec_digit;
   logic            dec_is_digit;
   logic            accept;

   ps2_digit_decode u_decode (
      .code     (sc_data),
      .digit    (dec_digit),
      .is_digit (dec_is_digit)
   );

   assign sc_ready  = (state_q != COMMIT);
   assign num_valid = (state_q == COMMIT);
   assign num_bcd   = buf_q;
   assign num_len   = len_q;
   assign overflow  = ovf_q;
   assign ignored   = ign_q;
   assign accept    = sc_valid & sc_ready;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= IDLE;
         buf_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
         ign_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
         ign_q   <= ign_d;
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      len_d   = len_q;
      ovf_d   = 1'b0;
      ign_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (sc_data == SC_EXT) begin
                  state_d = EXT;
               end else if (sc_data == SC_BRK) begin
                  state_d = BRK;
               end else if (dec_is_digit) begin
                  if (len_q < LW'(NDIG)) begin
                     buf_d = (buf_q << 4) | BW'(dec_digit);
                     len_d = len_q + LW'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else if (sc_data == SC_BKSP) begin
                  if (len_q != '0) begin
                     buf_d = buf_q >> 4;
                     len_d = len_q - LW'(1);
                  end
               end else if (sc_data == SC_ESC) begin
                  buf_d = '0;
                  len_d = '0;
               end else if (sc_data == SC_ENTER) begin
                  if (len_q != '0) state_d = COMMIT;
               end else begin
                  ign_d = 1'b1;
               end
            end
         end
         EXT: begin
            if (accept) begin
               if (sc_data == SC_BRK)
                  state_d = EXT_BRK;
               else if (sc_data == SC_ENTER && len_q != '0)
                  state_d = COMMIT;
               else
                  state_d = IDLE;
            end
         end
         BRK, EXT_BRK: begin
            // The released key's code is swallowed; break codes never edit the buffer.
            if (accept) state_d = IDLE;
         end
         COMMIT: begin
            if (num_ready) begin
               buf_d   = '0;
               len_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ps2_digit_entry_ctrl.sv
// Directed self-checking bench for ps2_digit_entry_ctrl with NDIG=4.
module tb_ps2_digit_entry_ctrl;

   logic        clk;
   logic        areset_n;
   logic        sc_valid;
   logic [7:0]  sc_data;
   logic        sc_ready;
   logic        num_valid;
   logic        num_ready;
   logic [15:0] num_bcd;
   logic [2:0]  num_len;
   logic        overflow;
   logic        ignored;

   int n_cmp;
   int n_err;

   ps2_digit_entry_ctrl #(.NDIG(4)) dut (
      .clk       (clk),
      .areset_n  (areset_n),
      .sc_valid  (sc_valid),
      .sc_data   (sc_data),
      .sc_ready  (sc_ready),
      .num_valid (num_valid),
      .num_ready (num_ready),
      .num_bcd   (num_bcd),
      .num_len   (num_len),
      .overflow  (overflow),
      .ignored   (ignored)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks every observable output against the expected set.
   task automatic chk_all(input string tag, input logic [15:0] bcd, input logic [2:0] len,
                          input logic vld, input logic rdy, input logic ovf, input logic ign);
      chk({tag, "/bcd"}, 32'(num_bcd), 32'(bcd));
      chk({tag, "/len"}, 32'(num_len), 32'(len));
      chk({tag, "/num_valid"}, 32'(num_valid), 32'(vld));
      chk({tag, "/sc_ready"}, 32'(sc_ready), 32'(rdy));
      chk({tag, "/overflow"}, 32'(overflow), 32'(ovf));
      chk({tag, "/ignored"}, 32'(ignored), 32'(ign));
   endtask

   // Presents one byte for exactly one edge; returns #1 after that edge.
   task automatic send(input logic [7:0] b);
      sc_valid = 1'b1;
      sc_data  = b;
      @(posedge clk);
      #1;
      sc_valid = 1'b0;
      sc_data  = 8'h00;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      areset_n  = 1'b0;
      sc_valid  = 1'b0;
      sc_data   = 8'h00;
      num_ready = 1'b0;
      #2;
      chk_all("reset", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1 areset_n = 1'b1;

      // make/break pairs of 1 and 2, then Enter
      send(8'h16); chk_all("mk1", 16'h0001, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'hF0); send(8'h16);
      chk_all("brk1", 16'h0001, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h1E); send(8'hF0); send(8'h1E);
      chk_all("brk2", 16'h0012, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h5A);
      chk_all("commit12", 16'h0012, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      num_ready = 1'b1;
      idle_cycle();
      chk_all("hs12", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      num_ready = 1'b0;

      // fill buffer, fifth digit overflows
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
      chk_all("full", 16'h1234, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h2E);
      chk_all("ovf", 16'h1234, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
      idle_cycle();
      chk_all("ovf_end", 16'h1234, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h76);
      chk_all("esc", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      // edit with backspace, commit with keypad Enter
      send(8'h3D); send(8'h3E);
      chk_all("78", 16'h0078, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h66);
      chk_all("bksp", 16'h0007, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h26);
      chk_all("73", 16'h0073, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'hE0);
      chk_all("ext", 16'h0073, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h5A);
      chk_all("kp_enter", 16'h0073, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);

      // stalled commit ignores scancodes, then reset drops it immediately
      sc_valid = 1'b1;
      sc_data  = 8'h16;
      for (int i = 0; i < 10; i++) begin
         idle_cycle();
         chk_all("stall", 16'h0073, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      #2 areset_n = 1'b0;
      #1;
      chk_all("rst_commit", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      sc_valid = 1'b0;
      sc_data  = 8'h00;
      @(posedge clk);
      #1 areset_n = 1'b1;

      // no-op keys at len 0 and an unknown make code
      send(8'h5A);
      chk_all("enter0", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h66);
      chk_all("bksp0", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h1C);
      chk_all("ign", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle_cycle();
      chk_all("ign_end", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      // break sequences leave the buffer alone and return to IDLE
      send(8'h46);
      chk_all("9", 16'h0009, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'hF0); send(8'h45);
      chk_all("brk0", 16'h0009, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'hE0); send(8'hF0); send(8'h5A);
      chk_all("ext_brk", 16'h0009, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h36);
      chk_all("96", 16'h0096, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);

      // num_ready already high when Enter arrives: one COMMIT cycle
      num_ready = 1'b1;
      send(8'h5A);
      chk_all("early_rdy", 16'h0096, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_cycle();
      chk_all("early_hs", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      num_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
